// File: rtl/apb_slave_waitstate_if.sv
// APB bus bundle between a master and apb_slave_waitstate.
// Byte-wide data path with a pslaverr error response.
interface apb_slave_waitstate_if;
  logic       pselx;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslaverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslaverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslaverr
  );
endinterface

// File: rtl/apb_slave_waitstate.sv
// APB responder with a byte register file, a read-only ID register at 0xFF,
// a configurable number of wait states and a slave-error response.
module apb_slave_waitstate #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_slave_waitstate_if.slave  bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  LIMIT    = 8'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_write;
  logic        r_pready;
  logic        r_pslaverr;
  logic [7:0]  r_prdata;
  logic [7:0]  r_mem [DEPTH];

  logic          w_setup;
  logic          w_access;
  logic [7:0]    w_addr;
  logic          w_write;
  logic          w_in_range;
  logic          w_is_id;
  logic          w_err;
  logic [7:0]    w_rdata;
  logic [AW-1:0] w_idx;
  logic          w_commit;

  // Zero-wait transfers enter READY straight from IDLE, so decode the live
  // bus there; otherwise decode the request latched at the setup edge.
  always_comb begin
    w_setup    = bus.pselx && !bus.penable;
    w_access   = bus.pselx && bus.penable;
    w_addr     = (r_state == S_IDLE) ? bus.paddr  : r_addr;
    w_write    = (r_state == S_IDLE) ? bus.pwrite : r_write;
    w_in_range = w_addr < LIMIT;
    w_is_id    = w_addr == 8'hFF;
    w_idx      = w_addr[AW-1:0];
    w_err      = w_is_id ? w_write : !w_in_range;
    w_rdata    = '0;
    if (!w_write) begin
      if (w_in_range)   w_rdata = r_mem[w_idx];
      else if (w_is_id) w_rdata = ID_VALUE;
    end
    w_commit   = (r_state == S_READY) && w_access && r_write && !r_pslaverr;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_pready   <= 1'b0;
      r_pslaverr <= 1'b0;
      r_prdata   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_commit) r_mem[r_addr[AW-1:0]] <= r_wdata;
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_addr  <= bus.paddr;
            r_write <= bus.pwrite;
            r_wdata <= bus.pwdata;
            if (WAIT_CYCLES == 0) begin
              r_state    <= S_READY;
              r_pready   <= 1'b1;
              r_pslaverr <= w_err;
              r_prdata   <= w_rdata;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.pselx) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (bus.penable) begin
            if (r_cnt == 4'd1) begin
              r_state    <= S_READY;
              r_cnt      <= '0;
              r_pready   <= 1'b1;
              r_pslaverr <= w_err;
              r_prdata   <= w_rdata;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        S_READY: begin
          r_state    <= S_IDLE;
          r_pready   <= 1'b0;
          r_pslaverr <= 1'b0;
          r_prdata   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pready   = r_pready;
  assign bus.pslaverr = r_pslaverr;
  assign bus.prdata   = r_prdata;

endmodule

// File: tb/tb_apb_slave_waitstate.sv
// Directed bench for apb_slave_waitstate: one instance with two wait states,
// one with none, checked against a queue of expected responses.
module tb_apb_slave_waitstate;

  logic       clk = 1'b0;
  logic       rst;
  logic       t_which;
  logic       t_psel;
  logic       t_pen;
  logic       t_pwrite;
  logic [7:0] t_paddr;
  logic [7:0] t_pwdata;

  always #5 clk = ~clk;

  apb_slave_waitstate_if b0();
  apb_slave_waitstate_if b1();

  assign b0.pselx   = t_psel & ~t_which;
  assign b0.penable = t_pen;
  assign b0.pwrite  = t_pwrite;
  assign b0.paddr   = t_paddr;
  assign b0.pwdata  = t_pwdata;
  assign b1.pselx   = t_psel & t_which;
  assign b1.penable = t_pen;
  assign b1.pwrite  = t_pwrite;
  assign b1.paddr   = t_paddr;
  assign b1.pwdata  = t_pwdata;

  apb_slave_waitstate #(.DEPTH(16), .WAIT_CYCLES(2), .ID_VALUE(8'hA5)) u_dut_w2 (
    .pclk(clk), .preset(rst), .bus(b0)
  );
  apb_slave_waitstate #(.DEPTH(16), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) u_dut_w0 (
    .pclk(clk), .preset(rst), .bus(b1)
  );

  logic       obs_ready;
  logic       obs_err;
  logic [7:0] obs_rd;
  assign obs_ready = t_which ? b1.pready   : b0.pready;
  assign obs_err   = t_which ? b1.pslaverr : b0.pslaverr;
  assign obs_rd    = t_which ? b1.prdata   : b0.prdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [7:0]  rd;
    logic        err;
    bit          chk_rd;
    int unsigned lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    t_psel = 1'b0;
    t_pen  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Leaves pselx/penable high after the READY edge so a following call
  // starts its setup phase immediately (back-to-back).
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input logic exp_err);
    exp_t        e;
    exp_t        p;
    int unsigned cyc;
    bit          done;
    e.rd     = exp_rd;
    e.err    = exp_err;
    e.chk_rd = !wr;
    e.lat    = t_which ? 0 : 2;
    sb.push_back(e);
    t_psel   = 1'b1;
    t_pen    = 1'b0;
    t_pwrite = wr;
    t_paddr  = a;
    t_pwdata = d;
    @(negedge clk);
    chk("setup_pready", 32'(obs_ready), 32'd0);
    @(posedge clk); #1;
    t_pen = 1'b1;
    cyc   = 0;
    done  = 1'b0;
    while (!done && cyc < 32) begin
      @(negedge clk);
      if (obs_ready === 1'b1) begin
        p = sb.pop_front();
        chk("ready_latency", 32'(cyc), 32'(p.lat));
        chk("pslaverr", 32'(obs_err), 32'(p.err));
        if (p.chk_rd) chk("prdata", 32'(obs_rd), 32'(p.rd));
        done = 1'b1;
      end else begin
        cyc++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout addr=%0h observed=no_pready expected=pready", a);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    t_which  = 1'b0;
    t_psel   = 1'b0;
    t_pen    = 1'b0;
    t_pwrite = 1'b0;
    t_paddr  = '0;
    t_pwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready_w2", 32'(b0.pready), 32'd0);
    chk("rst_pslaverr_w2", 32'(b0.pslaverr), 32'd0);
    chk("rst_prdata_w2", 32'(b0.prdata), 32'd0);
    chk("rst_pready_w0", 32'(b1.pready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two wait states: write/read, ID register, out-of-range decode.
    xfer(1'b1, 8'h05, 8'h3C, 8'h00, 1'b0);
    xfer(1'b0, 8'h05, 8'h00, 8'h3C, 1'b0);
    idle(1);
    xfer(1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0);
    xfer(1'b1, 8'hFF, 8'h11, 8'h00, 1'b1);
    xfer(1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0);
    xfer(1'b1, 8'h00, 8'h5A, 8'h00, 1'b0);
    xfer(1'b1, 8'h10, 8'h77, 8'h00, 1'b1);
    xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    xfer(1'b0, 8'h00, 8'h00, 8'h5A, 1'b0);

    // Access phase with no preceding setup must be ignored.
    t_psel   = 1'b1;
    t_pen    = 1'b1;
    t_pwrite = 1'b0;
    t_paddr  = 8'h05;
    repeat (3) begin
      @(negedge clk);
      chk("no_setup_pready", 32'(obs_ready), 32'd0);
      @(posedge clk); #1;
    end
    idle(1);

    // Zero wait states, back-to-back.
    t_which = 1'b1;
    xfer(1'b1, 8'h01, 8'h11, 8'h00, 1'b0);
    xfer(1'b1, 8'h02, 8'h22, 8'h00, 1'b0);
    xfer(1'b1, 8'h03, 8'h33, 8'h00, 1'b0);
    xfer(1'b0, 8'h01, 8'h00, 8'h11, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 8'h22, 1'b0);
    xfer(1'b0, 8'h03, 8'h00, 8'h33, 1'b0);
    idle(1);

    // Abort: drop pselx in the first wait cycle with penable still high.
    t_which  = 1'b0;
    t_psel   = 1'b1;
    t_pen    = 1'b0;
    t_pwrite = 1'b1;
    t_paddr  = 8'h04;
    t_pwdata = 8'h99;
    @(posedge clk); #1;
    t_psel = 1'b0;
    t_pen  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_pready", 32'(obs_ready), 32'd0);
      @(posedge clk); #1;
    end
    idle(1);
    xfer(1'b0, 8'h04, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Reset on the edge that would otherwise enter READY.
    t_psel   = 1'b1;
    t_pen    = 1'b0;
    t_pwrite = 1'b1;
    t_paddr  = 8'h04;
    t_pwdata = 8'h55;
    @(posedge clk); #1;
    t_pen = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    t_psel = 1'b0;
    t_pen  = 1'b0;
    @(negedge clk);
    chk("reset_pready", 32'(b0.pready), 32'd0);
    chk("reset_pslaverr", 32'(b0.pslaverr), 32'd0);
    chk("reset_prdata", 32'(b0.prdata), 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 8'h04, 8'h00, 8'h00, 1'b0);
    xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
    idle(1);
    t_which = 1'b1;
    xfer(1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_waitstate.md
# apb_slave_waitstate

APB responder holding a small byte-wide register file, with a parameterised number of wait states and a slave-error response. It sits on the same pselx/penable/pwrite/paddr/pwdata bus driven by apb_master and is a drop-in alternative to apb_slave_1. Its purpose is to exercise the master's pready stall and pslaverr paths. Every output is registered; the data path is 8-bit.

## Interface
- DEPTH, 16: number of read/write byte registers, at addresses 0x00..DEPTH-1 (1..255).
- WAIT_CYCLES, 2: wait states inserted in every access phase (0..15).
- ID_VALUE, 8'hA5: value returned by the read-only ID register at address 0xFF.
- pclk  input  1  clock; all logic on rising edge.
- preset  input  1  reset, synchronous, active-high.
- pselx  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address.
- pwdata  input  8  write data.
- prdata  output  8  read data; valid only while pready=1.
- pready  output  1  transfer-complete strobe.
- pslaverr  output  1  error response; valid only while pready=1.

## Operation
- State machine has three states:
  - IDLE: pready=0, pslaverr=0, prdata=0.
  - WAIT: counting wait states.
  - READY: pready=1 for exactly one cycle.
- IDLE -> WAIT or READY: at the edge sampling pselx=1 and penable=0 (setup phase).
  - Latch paddr, pwrite and pwdata.
  - If WAIT_CYCLES=0, go to READY directly.
  - Otherwise go to WAIT with counter = WAIT_CYCLES.
- WAIT:
  - Counter decrements each edge while pselx=1 and penable=1.
  - When the counter reaches 1, go to READY.
  - If penable=0 in WAIT, hold (no decrement).
- READY:
  - pready=1 and pslaverr/prdata are driven from the latched request.
  - Always return to IDLE at the next edge.
- Decode of the latched address:
  - Below DEPTH: normal register access. Read returns mem[addr]; write stores pwdata.
  - 0xFF with read: returns ID_VALUE, pslaverr=0.
  - 0xFF with write: pslaverr=1, nothing stored.
  - Any other address (DEPTH..0xFE): pslaverr=1, prdata=0, nothing stored.
- Write commit:
  - Occurs at the edge ending the READY cycle, only if pselx=1 and penable=1 and no error.
  - No partial or early writes.
- Abort: pselx=0 while in WAIT or READY returns the block to IDLE at that edge.
  - No write is performed and pready falls.
- Reset: preset=1 at an edge forces IDLE, all outputs to 0, counter to 0 and every mem entry to 0.
  - Applies mid-transfer too; the in-flight write is discarded.

## Timing
- Setup phase is cycle T0; the access phase begins at T1.
- pready is high only during cycle T1+WAIT_CYCLES, so a transfer takes WAIT_CYCLES+2 cycles from pselx rising.
- prdata and pslaverr change only on edges entering READY or IDLE; both are 0 outside READY.
- Read latency from the setup edge to valid prdata is WAIT_CYCLES+1 edges.
- Written data is readable from the next transfer's READY cycle.
- Back-to-back transfers:
  - A new setup phase is accepted in the cycle right after READY.
  - No idle cycle is required between transfers.
- pselx=1 with penable=1 while in IDLE, with no prior setup, is ignored: the block stays in IDLE and pready stays 0.
- Reset has priority over every transfer event on the same edge.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - Write 0x3C to 0x05; pready must be high only in the 3rd access-phase cycle and pslaverr=0.
  - A subsequent read of 0x05 must return prdata=0x3C in its ready cycle.
- ID register:
  - Read 0xFF -> prdata=0xA5, pslaverr=0.
  - Write 0x11 to 0xFF -> pslaverr=1; a re-read still returns 0xA5.
- Out of range, DEPTH=16:
  - Write 0x77 to 0x10 -> pslaverr=1 in the ready cycle.
  - A read of 0x10 -> prdata=0x00, pslaverr=1.
  - mem[0x00] remains unchanged.
- Back-to-back, WAIT_CYCLES=0:
  - Writes to 0x01, 0x02, 0x03 with no idle cycles -> pready high every second cycle.
  - All three values read back correctly.
- Abort and reset:
  - Drop pselx in the 1st wait cycle of a write of 0x99 to 0x04 -> pready never rises and mem[0x04] stays 0.
  - Assert preset during the WAIT of another write -> all outputs 0 next cycle and a read of 0x04 returns 0x00.
